seg7_scan_driver: RTL and testbench

- Downstream display stage for the subtractor datapath.
- Captures a two-digit BCD result (tens, units) plus a sign flag from the binary-to-BCD stage.
- Drives a time-multiplexed, 3-digit, common-anode seven-segment display: sign, tens, units.
- Adds leading-zero blanking and a blinking "E" pattern when a captured digit is not valid BCD.

---
 rtl/seg7_scan_driver.sv | 156 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// seg7_scan_driver : 3-digit common-anode scan driver (sign, tens, units) with
//                    leading-zero blanking and a blinking "E" on invalid BCD.
// Revision: 1.0
// ============================================================================
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_TICKS = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  input  logic       neg,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       err
);

  localparam int            PW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int            BW        = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);
  localparam logic [6:0]    SEG_BLANK = 7'b1111111;
  localparam logic [6:0]    SEG_DASH  = 7'b0111111;
  localparam logic [6:0]    SEG_E     = 7'b0000110;

  typedef enum logic [1:0] {
    S_UNITS = 2'd0,
    S_TENS  = 2'd1,
    S_SIGN  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    units_q, units_d;
  logic          neg_q, neg_d;
  logic          err_q, err_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;
  logic          tick;
  logic          err_new;
  logic [3:0]    digit;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = 7'b1000000;
      4'd1:    bcd_to_seg = 7'b1111001;
      4'd2:    bcd_to_seg = 7'b0100100;
      4'd3:    bcd_to_seg = 7'b0110000;
      4'd4:    bcd_to_seg = 7'b0011001;
      4'd5:    bcd_to_seg = 7'b0010010;
      4'd6:    bcd_to_seg = 7'b0000010;
      4'd7:    bcd_to_seg = 7'b1111000;
      4'd8:    bcd_to_seg = 7'b0000000;
      4'd9:    bcd_to_seg = 7'b0010000;
      default: bcd_to_seg = SEG_BLANK;
    endcase
  endfunction

  // Prescaler, scan sequencing, capture and blink timing
  always_comb begin
    tick    = (pre_q == PRE_MAX);
    pre_d   = tick ? '0 : pre_q + 1'b1;
    err_new = (bcd1 > 4'd9) | (bcd0 > 4'd9);

    state_d = state_q;
    if (tick) begin
      case (state_q)
        S_UNITS: state_d = S_TENS;
        S_TENS:  state_d = S_SIGN;
        default: state_d = S_UNITS;
      endcase
    end

    tens_d  = load ? bcd1    : tens_q;
    units_d = load ? bcd0    : units_q;
    neg_d   = load ? neg     : neg_q;
    err_d   = load ? err_new : err_q;

    // Entering error mode restarts the blink so "E" always shows first
    blink_d = blink_q;
    phase_d = phase_q;
    if (load && err_new && !err_q) begin
      blink_d = '0;
      phase_d = 1'b1;
    end else if (!err_q) begin
      blink_d = '0;
      phase_d = 1'b1;
    end else if (tick) begin
      if (blink_q == BLINK_MAX) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
    end
  end

  // Output frame is built from the present slot and present captures
  always_comb begin
    case (state_q)
      S_UNITS: begin an_d = 3'b110; digit = units_q; end
      S_TENS:  begin an_d = 3'b101; digit = tens_q;  end
      default: begin an_d = 3'b011; digit = units_q; end
    endcase

    if (err_q) begin
      seg_d = phase_q ? SEG_E : SEG_BLANK;
    end else if (state_q == S_SIGN) begin
      seg_d = neg_q ? SEG_DASH : SEG_BLANK;
    end else if ((state_q == S_TENS) && blank_lz && (tens_q == 4'd0)) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = bcd_to_seg(digit);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_UNITS;
      pre_q   <= '0;
      blink_q <= '0;
      phase_q <= 1'b1;
      tens_q  <= 4'd0;
      units_q <= 4'd0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      seg_q   <= SEG_BLANK;
      an_q    <= 3'b111;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// tb_seg7_scan_driver : scoreboard bench for the 3-digit scan driver.
// Revision: 1.0
// ============================================================================
module tb_seg7_scan_driver;

  localparam int RD = 4;
  localparam int BT = 2;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [3:0] bcd1;
  logic [3:0] bcd0;
  logic       neg;
  logic       blank_lz;
  logic [6:0] seg;
  logic [2:0] an;
  logic       err;

  seg7_scan_driver #(
    .REFRESH_DIV(RD),
    .BLINK_TICKS(BT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .bcd1    (bcd1),
    .bcd0    (bcd0),
    .neg     (neg),
    .blank_lz(blank_lz),
    .seg     (seg),
    .an      (an),
    .err     (err)
  );

  typedef struct {
    int         cyc;
    logic [6:0] seg;
    logic [2:0] an;
    logic       err;
    int         id;
  } exp_t;

  exp_t q[$];
  exp_t mx;
  int   cyc    = 0;
  int   r_edge = 0;
  int   n_vec  = 0;
  int   n_bad  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output frame that has a queued expectation is compared
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mx = q.pop_front();
      n_vec++;
      if (mx.cyc != cyc || seg !== mx.seg || an !== mx.an || err !== mx.err) begin
        n_bad++;
        $display("FAIL t%0d cyc %0d (want cyc %0d): got seg=%b an=%b err=%b, want seg=%b an=%b err=%b",
                 mx.id, cyc, mx.cyc, seg, an, err, mx.seg, mx.an, mx.err);
      end
    end
  end

  function automatic logic [6:0] code(input int d);
    case (d)
      0:       code = 7'b1000000;
      1:       code = 7'b1111001;
      2:       code = 7'b0100100;
      3:       code = 7'b0110000;
      4:       code = 7'b0011001;
      5:       code = 7'b0010010;
      6:       code = 7'b0000010;
      7:       code = 7'b1111000;
      8:       code = 7'b0000000;
      9:       code = 7'b0010000;
      default: code = 7'b1111111;
    endcase
  endfunction

  function automatic logic [2:0] an_of(input int s);
    case (s)
      0:       an_of = 3'b110;
      1:       an_of = 3'b101;
      default: an_of = 3'b011;
    endcase
  endfunction

  function automatic logic [6:0] norm(input int s, input int t, input int u, input bit n, input bit blz);
    case (s)
      0:       norm = code(u);
      1:       norm = (blz && t == 0) ? 7'b1111111 : code(t);
      default: norm = n ? 7'b0111111 : 7'b1111111;
    endcase
  endfunction

  // Slot shown in the frame after edge e (edges counted from the reset edge)
  function automatic int slot(input int e);
    slot = ((e - 1) / RD) % 3;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_e(input int e);
    while (cyc - r_edge < e) step();
  endtask

  task automatic push(input int e, input logic [6:0] s, input logic [2:0] a, input logic er, input int id);
    exp_t x;
    x.cyc = r_edge + e;
    x.seg = s;
    x.an  = a;
    x.err = er;
    x.id  = id;
    q.push_back(x);
  endtask

  task automatic push_norm(input int e0, input int e1, input int t, input int u, input bit n,
                           input bit blz, input int id);
    for (int e = e0; e <= e1; e++) push(e, norm(slot(e), t, u, n, blz), an_of(slot(e)), 1'b0, id);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; bcd1 = 4'd0; bcd0 = 4'd0; neg = 1'b0; blank_lz = 1'b0;
    step(); step();
    rst_n = 1'b1;
    bcd1 = 4'd2; bcd0 = 4'd2; load = 1'b1;
    step();
    load = 1'b0;
    repeat (6) step();

    // Reset mid-scan with load held high: reset must win
    rst_n = 1'b0; load = 1'b1; bcd1 = 4'd9; bcd0 = 4'd9; neg = 1'b1;
    begin
      exp_t x;
      x.cyc = cyc + 1; x.seg = 7'h7F; x.an = 3'b111; x.err = 1'b0; x.id = 1;
      q.push_back(x);
    end
    step();
    r_edge = cyc;
    rst_n = 1'b1; load = 1'b0;
    push_norm(1, 2, 0, 0, 1'b0, 1'b0, 2);
    step();

    // 47 with negative sign, several full scan rounds
    bcd1 = 4'd4; bcd0 = 4'd7; neg = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    push_norm(3, 30, 4, 7, 1'b1, 1'b0, 3);

    // 03 with leading-zero blanking, then blanking released mid tens slot
    wait_e(29);
    bcd1 = 4'd0; bcd0 = 4'd3; neg = 1'b0; blank_lz = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    push_norm(31, 42, 0, 3, 1'b0, 1'b1, 4);
    wait_e(42);
    blank_lz = 1'b0;
    push_norm(43, 52, 0, 3, 1'b0, 1'b0, 5);

    // Load coincident with a scan tick
    wait_e(51);
    bcd1 = 4'd8; bcd0 = 4'd6; neg = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    push_norm(53, 63, 8, 6, 1'b1, 1'b0, 6);

    // Invalid BCD: err immediately, then E / blank every 2 ticks
    wait_e(63);
    bcd1 = 4'd12; bcd0 = 4'd5; neg = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    push(64, norm(slot(64), 8, 6, 1'b1, 1'b0), an_of(slot(64)), 1'b1, 7);
    for (int e = 65; e <= 89; e++)
      push(e, (((e - 1 - 64) / 8) % 2 == 0) ? 7'b0000110 : 7'b1111111, an_of(slot(e)), 1'b1, 8);

    // Valid value clears the error
    wait_e(89);
    bcd1 = 4'd1; bcd0 = 4'd5; neg = 1'b0; load = 1'b1;
    push(90, 7'b1111111, an_of(slot(90)), 1'b0, 9);
    step();
    load = 1'b0;
    push_norm(91, 102, 1, 5, 1'b0, 1'b0, 10);

    wait_e(104);
    step();
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
